// File: rtl/fifo_stream_drain_if.sv
// rtl/fifo_stream_drain_if.sv - FIFO read port and output stream bundle for fifo_stream_drain
interface fifo_stream_drain_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_empty;
    logic                  fifo_read_en;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    // Drain stage side: pops the FIFO and sources the stream
    modport master (
        input  fifo_dout,
        input  fifo_empty,
        output fifo_read_en,
        output m_data,
        output m_valid,
        input  m_ready
    );

    // Environment side: the FIFO and the stream consumer
    modport slave (
        output fifo_dout,
        output fifo_empty,
        input  fifo_read_en,
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/fifo_stream_drain.sv
// rtl/fifo_stream_drain.sv - sync_fifo read-side drain to valid/ready stream with 3-entry buffer
module fifo_stream_drain #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    fifo_stream_drain_if.master    bus,
    output logic [COUNT_WIDTH-1:0] words_sent
);
    // Occupancy states; values 1 and 2 are the partial state
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_FULL  = 2'd3;

    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q;
    logic [1:0]            head_q, head_d;
    logic [1:0]            tail_idx;
    logic [DATA_WIDTH-1:0] slot_q [0:2];
    logic [COUNT_WIDTH-1:0] words_sent_q;
    logic [2:0]            committed;
    logic [2:0]            tail_sum;
    logic                  read_en;
    logic                  pop;

    // Read issue uses only registered state so m_ready never reaches fifo_read_en
    always_comb begin
        committed = {1'b0, occ_q} + {2'b0, inflight_q};
        read_en   = reset && enable && !bus.fifo_empty && (committed < {1'b0, OCC_FULL});
        pop       = (occ_q != OCC_EMPTY) && bus.m_ready;
    end

    // Circular buffer bookkeeping: landing slot sits just past the held words
    always_comb begin
        tail_sum = {1'b0, head_q} + {1'b0, occ_q};
        tail_idx = (tail_sum >= 3'd3) ? 2'(tail_sum - 3'd3) : tail_sum[1:0];
        head_d   = head_q;
        if (pop) begin
            head_d = (head_q == 2'd2) ? 2'd0 : head_q + 2'd1;
        end
        occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    end

    // State update: land the in-flight word, retire the head, count transfers
    always_ff @(posedge clock) begin
        if (!reset) begin
            occ_q        <= OCC_EMPTY;
            inflight_q   <= 1'b0;
            head_q       <= 2'd0;
            words_sent_q <= '0;
            for (int i = 0; i < 3; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            occ_q      <= occ_d;
            inflight_q <= read_en;
            head_q     <= head_d;
            if (inflight_q) begin
                slot_q[tail_idx] <= bus.fifo_dout;
            end
            if (pop) begin
                words_sent_q <= words_sent_q + 1'b1;
            end
        end
    end

    assign bus.fifo_read_en = read_en;
    assign bus.m_valid      = (occ_q != OCC_EMPTY);
    assign bus.m_data       = slot_q[head_q];
    assign words_sent       = words_sent_q;
endmodule

// File: tb/tb_fifo_stream_drain.sv
// tb/tb_fifo_stream_drain.sv - directed bench with sync_fifo model and scoreboard
module tb_fifo_stream_drain;
    logic        clock;
    logic        reset;
    logic        enable;
    logic        enable4;
    logic [15:0] words_sent;
    logic [3:0]  words_sent4;

    fifo_stream_drain_if #(.DATA_WIDTH(32)) bus ();
    fifo_stream_drain_if #(.DATA_WIDTH(32)) bus4 ();

    fifo_stream_drain #(.DATA_WIDTH(32), .COUNT_WIDTH(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .bus        (bus.master),
        .words_sent (words_sent)
    );

    fifo_stream_drain #(.DATA_WIDTH(32), .COUNT_WIDTH(4)) dut4 (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable4),
        .bus        (bus4.master),
        .words_sent (words_sent4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          rd_cnt = 0;
    int          fall_cyc = 0;
    logic        prev_empty = 1'b1;
    logic [31:0] sb[$];
    int          pop_cyc[$];
    logic [31:0] fmem[$];
    logic        wr_en;
    logic [31:0] wr_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // sync_fifo model: registered empty flag, read data one cycle after read_en
    always @(posedge clock) begin
        if (!reset) begin
            fmem = {};
            bus.fifo_dout  <= '0;
            bus.fifo_empty <= 1'b1;
        end else begin
            if (bus.fifo_read_en && !bus.fifo_empty) begin
                bus.fifo_dout <= fmem.pop_front();
            end
            if (wr_en) begin
                fmem.push_back(wr_data);
            end
            bus.fifo_empty <= (fmem.size() == 0);
        end
    end

    // Stream monitor away from the active edge: scoreboard and underflow checks
    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            chk("read_while_empty", {31'd0, bus.fifo_read_en && bus.fifo_empty}, 32'd0);
            if (bus.fifo_read_en && !bus.fifo_empty) rd_cnt++;
            if (prev_empty && !bus.fifo_empty) fall_cyc = cyc;
            if (bus.m_valid && bus.m_ready) begin
                pop_cyc.push_back(cyc);
                total++;
                assert (sb.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_pop observed=%0h expected=none", bus.m_data);
                end
                if (sb.size() != 0) chk("m_data", bus.m_data, sb.pop_front());
            end
        end
        prev_empty = bus.fifo_empty;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fifo_write(input logic [31:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        sb.push_back(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        repeat (2) tick();
        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL drain_timeout observed=%0d expected=0", sb.size());
        end
    endtask

    initial begin
        reset   = 1'b0;
        enable  = 1'b0;
        enable4 = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        bus.m_ready     = 1'b1;
        bus4.m_ready    = 1'b0;
        bus4.fifo_empty = 1'b0;
        bus4.fifo_dout  = 32'h77;

        // 1: reset state
        repeat (2) tick();
        chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("rst_read_en", {31'd0, bus.fifo_read_en}, 32'd0);
        chk("rst_words_sent", {16'd0, words_sent}, 32'd0);
        reset = 1'b1;
        tick();

        // 2: eight words streamed back to back
        for (int i = 1; i <= 8; i++) fifo_write(32'(i));
        tick();
        pop_cyc = {};
        enable = 1'b1;
        wait_drain();
        chk("t2_words_sent", {16'd0, words_sent}, 32'd8);
        chk("t2_pops", pop_cyc.size(), 32'd8);
        chk("t2_consecutive", pop_cyc[7] - pop_cyc[0], 32'd7);

        // 3: backpressure fills exactly three slots, then drains without gaps
        enable = 1'b0;
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) fifo_write(32'(i));
        tick();
        rd_cnt = 0;
        enable = 1'b1;
        repeat (8) tick();
        chk("t3_reads", rd_cnt, 32'd3);
        chk("t3_read_en_off", {31'd0, bus.fifo_read_en}, 32'd0);
        chk("t3_m_valid", {31'd0, bus.m_valid}, 32'd1);
        chk("t3_head_held", bus.m_data, 32'h1);
        pop_cyc = {};
        bus.m_ready = 1'b1;
        wait_drain();
        chk("t3_pops", pop_cyc.size(), 32'd8);
        chk("t3_consecutive", pop_cyc[7] - pop_cyc[0], 32'd7);
        chk("t3_words_sent", {16'd0, words_sent}, 32'd16);

        // 4: single word latency from fifo_empty falling
        pop_cyc = {};
        fifo_write(32'hA5);
        repeat (6) tick();
        chk("t4_pops", pop_cyc.size(), 32'd1);
        chk("t4_latency", pop_cyc[0] - fall_cyc, 32'd2);

        // 5: enable dropped right after a read is issued
        enable = 1'b0;
        fifo_write(32'h51);
        fifo_write(32'h52);
        repeat (2) tick();
        rd_cnt = 0;
        pop_cyc = {};
        enable = 1'b1;
        tick();
        enable = 1'b0;
        repeat (6) tick();
        chk("t5_reads", rd_cnt, 32'd1);
        chk("t5_pops", pop_cyc.size(), 32'd1);
        chk("t5_read_en_off", {31'd0, bus.fifo_read_en}, 32'd0);
        enable = 1'b1;
        wait_drain();
        chk("t5_pops_after", pop_cyc.size(), 32'd2);

        // 6: reset with a full buffer discards everything
        bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_write(32'hC0 + 32'(i));
        repeat (6) tick();
        chk("t6_full_valid", {31'd0, bus.m_valid}, 32'd1);
        chk("t6_full_read_en", {31'd0, bus.fifo_read_en}, 32'd0);
        reset = 1'b0;
        tick();
        chk("t6_rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("t6_rst_words_sent", {16'd0, words_sent}, 32'd0);
        chk("t6_rst_read_en", {31'd0, bus.fifo_read_en}, 32'd0);
        sb = {};
        reset = 1'b1;
        enable = 1'b0;
        tick();

        // 6b: narrow counter wraps after 17 transfers
        enable4 = 1'b1;
        repeat (5) tick();
        bus4.m_ready = 1'b1;
        repeat (17) tick();
        bus4.m_ready = 1'b0;
        tick();
        chk("t6_wrap_words_sent", {28'd0, words_sent4}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
